fifo_stream_reader: RTL
=======================

// Module: fifo_stream_reader
// PURPOSE
//  Read-side engine for the synchronous FIFO. Pops words through the FIFO read port
//  (rd_en, then registered rd_data one cycle later, gated by empty). Presents them as
//  a valid/ready stream with a 2-entry skid buffer and frame-boundary marking.
//  Sits between the sample FIFO and downstream consumers (packetiser, UART/SPI TX).
// PARAMETERS
//  DW         8  data width, matches FIFO DW
//  FRAME_LEN  4  beats per frame, >=1; m_last_o marks beat FRAME_LEN-1
//  CW         $clog2(FRAME_LEN)>0 ? $clog2(FRAME_LEN) : 1  frame counter width (derived)
// PORTS
//  clk             in   1   clock; all logic on posedge
//  rst_n           in   1   asynchronous, active-low reset
//  en_i            in   1   allow new pops; buffered/in-flight beats drain regardless
//  fifo_empty_i    in   1   FIFO empty flag
//  fifo_rd_en_o    out  1   FIFO read request (combinational)
//  fifo_rd_data_i  in   DW  FIFO read data, valid the cycle after an accepted pop
//  m_data_o        out  DW  stream data (head of skid buffer, registered)
//  m_valid_o       out  1   stream valid (registered)
//  m_last_o        out  1   current beat is last of frame
//  m_ready_i       in   1   downstream ready
//  beat_cnt_o      out  CW  index of current beat within frame
// BEHAVIOUR
//  Reset (rst_n=0, async): occ=0, inflight=0, frame cnt=0.
//   Also m_valid_o=0, m_data_o=0, beat_cnt_o=0, m_last_o=(FRAME_LEN==1).
//   Any beat in flight or buffered at reset is discarded; the FIFO side is not re-read.
//  Definitions:
//   pop    = fifo_rd_en_o & ~fifo_empty_i
//   hs     = m_valid_o & m_ready_i
//   credit = occ + inflight (0..2)
//  fifo_rd_en_o = en_i & ~fifo_empty_i & ((credit<2) | (credit==2 & hs)).
//   Never asserted while empty.
//  inflight <= pop. The beat captured next cycle comes from fifo_rd_data_i
//   when inflight==1.
//  Skid buffer: head/tail regs, occ 0..2; m_data_o=head, m_valid_o=(occ!=0).
//   occ 0, capture           -> head=data, occ=1
//   occ 1, capture, no hs    -> tail=data, occ=2
//   occ 1, capture & hs      -> head=data, occ=1
//   occ 1, hs only           -> occ=0
//   occ 2, hs (no capture)   -> head=tail, occ=1
//   occ 2, hs & capture      -> head=tail, tail=data, occ=2
//   occ 2, capture & no hs   -> unreachable by credit rule; flag with an assertion
//  Order preserved; no word dropped or duplicated.
//  m_data_o must be stable while m_valid_o=1 and m_ready_i=0.
//  Latency: first pop at cycle N (empty low, credit 0) -> m_valid_o high from N+2.
//  Throughput: 1 beat/cycle sustained while the FIFO is non-empty and m_ready_i=1.
//  Frame counter: increments on hs; wraps FRAME_LEN-1 -> 0.
//   m_last_o = (cnt==FRAME_LEN-1). Counter is not altered by en_i.
//  Boundaries:
//   - FIFO goes empty mid-stream: m_valid_o drops once the buffer drains.
//     The frame count is held; partial frames are continued, not restarted.
//   - en_i falls: no new pop that cycle; the in-flight beat is still captured.
//   - m_ready_i held low: at most 2 words leave the FIFO, then fifo_rd_en_o=0.
//   - simultaneous hs and capture at occ 1 or 2: handled per table, no bubble.
//   - rst_n asserted mid-frame: everything returns to reset values immediately.
// TESTING
//  1. FIFO preloaded 0x11..0x18, en_i=1, m_ready_i=1.
//     -> m_valid_o rises 2 cycles after first pop; 8 back-to-back beats in order.
//     -> m_last_o on 0x14 and 0x18.
//  2. FIFO holds 5 words, m_ready_i=0 for 10 cycles.
//     -> exactly 2 pops; m_data_o stable at 1st word.
//     -> after ready rises: remaining 5 words in order, no gaps beyond refill.
//  3. m_ready_i toggles 1010..., 16 words.
//     -> all 16 delivered in order, none duplicated.
//     -> beat_cnt_o sequence 0,1,2,3,0.. on handshakes.
//  4. en_i dropped after 3 pops.
//     -> the 3 words are still delivered; no further fifo_rd_en_o until en_i=1.
//  5. rst_n pulsed low with occ=2 mid-frame.
//     -> m_valid_o=0, beat_cnt_o=0 same cycle; after release, the next FIFO word is beat 0.
//  6. FIFO empty throughout.
//     -> fifo_rd_en_o never 1, m_valid_o stays 0.

Source files
------------

// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - FIFO read engine feeding a valid/ready stream
// through a 2-entry skid buffer, with frame-boundary marking.
module fifo_stream_reader #(
  parameter int DW        = 8,
  parameter int FRAME_LEN = 4,
  localparam int CW       = ($clog2(FRAME_LEN) > 0) ? $clog2(FRAME_LEN) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en_i,
  input  logic          fifo_empty_i,
  output logic          fifo_rd_en_o,
  input  logic [DW-1:0] fifo_rd_data_i,
  output logic [DW-1:0] m_data_o,
  output logic          m_valid_o,
  output logic          m_last_o,
  input  logic          m_ready_i,
  output logic [CW-1:0] beat_cnt_o
);

  logic [1:0]    occ;
  logic          inflight;
  logic [DW-1:0] head;
  logic [DW-1:0] tail;
  logic [CW-1:0] cnt;
  logic [2:0]    credit;
  logic          hs;
  logic          pop;
  logic          cnt_last;

  // Credit counts buffered beats plus the one whose read data arrives next cycle,
  // so the buffer can never be asked to hold a third word.
  assign credit       = {1'b0, occ} + {2'b0, inflight};
  assign hs           = m_valid_o & m_ready_i;
  assign fifo_rd_en_o = en_i & ~fifo_empty_i &
                        ((credit < 3'd2) | ((credit == 3'd2) & hs));
  assign pop          = fifo_rd_en_o & ~fifo_empty_i;

  assign cnt_last   = (cnt == CW'(FRAME_LEN - 1));
  assign m_data_o   = head;
  assign m_valid_o  = (occ != 2'd0);
  assign m_last_o   = cnt_last;
  assign beat_cnt_o = cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ      <= 2'd0;
      inflight <= 1'b0;
      head     <= '0;
      tail     <= '0;
      cnt      <= '0;
    end else begin
      inflight <= pop;

      if (hs) begin
        cnt <= cnt_last ? '0 : cnt + CW'(1);
      end

      // inflight doubles as "capture fifo_rd_data_i this cycle".
      case (occ)
        2'd0: begin
          if (inflight) begin
            head <= fifo_rd_data_i;
            occ  <= 2'd1;
          end
        end
        2'd1: begin
          if (inflight && !hs) begin
            tail <= fifo_rd_data_i;
            occ  <= 2'd2;
          end else if (inflight && hs) begin
            head <= fifo_rd_data_i;
          end else if (hs) begin
            occ <= 2'd0;
          end
        end
        2'd2: begin
          if (hs) begin
            head <= tail;
            if (inflight) begin
              tail <= fifo_rd_data_i;
            end else begin
              occ <= 2'd1;
            end
          end
        end
        default: occ <= 2'd0;
      endcase
    end
  end

  always @(posedge clk) begin
    if (rst_n) begin
      assert (!((occ == 2'd2) && inflight && !hs));
    end
  end

endmodule
